// File: rtl/fdivsqrt_iter_ctrl.sv
// Iteration controller for a digit-recurrence divide/sqrt unit: sequences
// operand load, a programmable number of recurrence steps, and result hand-off.
module fdivsqrt_iter_ctrl #(
   parameter int DURLEN = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              FDivStartE,
   input  logic [DURLEN-1:0] CyclesE,
   input  logic              SpecialCaseE,
   input  logic              StallM,
   input  logic              FlushE,
   output logic              IFDivStartE,
   output logic              StepEnE,
   output logic              FDivBusyE,
   output logic              FDivDoneE,
   output logic [DURLEN-1:0] StepE
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [DURLEN-1:0] STEP_ZERO = {DURLEN{1'b0}};
   localparam logic [DURLEN-1:0] STEP_ONE  = {{(DURLEN-1){1'b0}}, 1'b1};

   // A zero iteration count still needs one recurrence step to settle the datapath.
   function automatic logic [DURLEN-1:0] load_count(input logic [DURLEN-1:0] cycles);
      if (cycles == STEP_ZERO) begin
         load_count = STEP_ONE;
      end else begin
         load_count = cycles;
      end
   endfunction

   state_t            state_q, state_d;
   logic [DURLEN-1:0] step_q, step_d;
   logic              step_en_q, step_en_d;
   logic              done_q, done_d;
   logic              accept_s;

   assign accept_s = FDivStartE & (state_q == IDLE) & ~FlushE & ~SpecialCaseE;

   // Next-state and step-counter logic; flush overrides every other condition.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      if (FlushE) begin
         state_d = IDLE;
         step_d  = STEP_ZERO;
      end else begin
         case (state_q)
            IDLE: begin
               if (FDivStartE) begin
                  if (SpecialCaseE) begin
                     state_d = DONE;
                     step_d  = STEP_ZERO;
                  end else begin
                     state_d = BUSY;
                     step_d  = load_count(CyclesE);
                  end
               end else begin
                  state_d = IDLE;
                  step_d  = STEP_ZERO;
               end
            end
            BUSY: begin
               if (step_q <= STEP_ONE) begin
                  state_d = DONE;
                  step_d  = STEP_ZERO;
               end else begin
                  state_d = BUSY;
                  step_d  = step_q - STEP_ONE;
               end
            end
            DONE: begin
               step_d = STEP_ZERO;
               if (StallM) begin
                  state_d = DONE;
               end else begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               step_d  = STEP_ZERO;
            end
         endcase
      end
   end

   // Status flags decoded from the next state so they leave the block registered.
   always_comb begin
      step_en_d = 1'b0;
      done_d    = 1'b0;
      case (state_d)
         BUSY: begin
            step_en_d = 1'b1;
            done_d    = 1'b0;
         end
         DONE: begin
            step_en_d = 1'b0;
            done_d    = 1'b1;
         end
         default: begin
            step_en_d = 1'b0;
            done_d    = 1'b0;
         end
      endcase
   end

   // State, counter and status registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         step_q    <= STEP_ZERO;
         step_en_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         step_en_q <= step_en_d;
         done_q    <= done_d;
      end
   end

   assign IFDivStartE = accept_s;
   assign StepEnE     = step_en_q;
   assign FDivDoneE   = done_q;
   assign StepE       = step_q;
   // Busy covers the accept cycle too, so the hazard unit stalls before state changes.
   assign FDivBusyE   = step_en_q | (done_q & StallM) | accept_s;

endmodule
